stepper_axis_ctrl: RTL

Parametrised single-axis stepper motor controller, the next generation of the board's per-motor control block; one instance per gantry axis. It accepts a move request (direction, step count, step period), sequences the four coil outputs in full-step or half-step mode at a programmable rate, and honours the per-direction boundary switches. It reports completion with a one-cycle done pulse, an abort flag and the number of steps actually issued.

---
 rtl/stepper_pkg.sv | 24 ++
 rtl/stepper_phase_seq.sv | 35 +++
 rtl/stepper_axis_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper axis controller: phase tables, FSM states
// and direction encoding.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  // Element [0] is the rightmost entry, so these read from the highest index down.
  localparam logic [3:0][3:0] FULL_STEP_TBL = {4'b1001, 4'b0011, 4'b0110, 4'b1100};
  localparam logic [7:0][3:0] HALF_STEP_TBL = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                               4'b0110, 4'b0100, 4'b1100, 4'b1000};

  function automatic logic [3:0] phase_pattern(input logic half, input logic [2:0] idx);
    if (half) phase_pattern = HALF_STEP_TBL[idx];
    else      phase_pattern = FULL_STEP_TBL[idx[1:0]];
  endfunction

endpackage

// File: rtl/stepper_phase_seq.sv
// Phase index register and coil pattern lookup; the index walks forward or
// backward one entry per advance and wraps within the 4- or 8-entry table.
module stepper_phase_seq
  import stepper_pkg::*;
#(
  parameter bit HALF_STEP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       dir,
  output logic [3:0] pattern
);

  localparam logic [2:0] IDX_MASK = HALF_STEP ? 3'd7 : 3'd3;

  logic [2:0] idx_q;
  logic [2:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (advance) begin
      if (dir == DIR_BWD) idx_d = (idx_q - 3'd1) & IDX_MASK;
      else                idx_d = (idx_q + 3'd1) & IDX_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= 3'd0;
    else     idx_q <= idx_d;
  end

  assign pattern = phase_pattern(HALF_STEP, idx_q);

endmodule

// File: rtl/stepper_axis_ctrl.sv
// Single-axis stepper controller: accepts a move, paces steps with a period
// timer, stops on count exhaustion or on the active boundary switch.
module stepper_axis_ctrl
  import stepper_pkg::*;
#(
  parameter int STEP_W    = 12,
  parameter int DIV_W     = 16,
  parameter bit HALF_STEP = 1'b0,
  parameter bit HOLD      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [STEP_W-1:0] steps,
  input  logic [DIV_W-1:0]  period,
  input  logic              limit_fwd,
  input  logic              limit_bwd,
  output logic [3:0]        coils,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_taken
);

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [DIV_W-1:0]  period_m1_q, period_m1_d;
  logic [DIV_W-1:0]  timer_q, timer_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic [STEP_W-1:0] steps_taken_q, steps_taken_d;
  logic              aborted_q, aborted_d;
  logic              energised_q, energised_d;

  logic              limit_start, limit_run;
  logic              start_acc, boundary, step_fire;
  logic [DIV_W-1:0]  period_in_m1;
  logic [3:0]        pattern;

  assign limit_start  = (dir == DIR_BWD) ? limit_bwd : limit_fwd;
  assign limit_run    = (dir_q == DIR_BWD) ? limit_bwd : limit_fwd;
  assign start_acc    = (state_q == IDLE) && start;
  assign boundary     = (state_q == RUN) && (timer_q == '0);
  assign step_fire    = boundary && !limit_run;
  assign period_in_m1 = (period == '0) ? '0 : period - DIV_W'(1);

  stepper_phase_seq #(
    .HALF_STEP (HALF_STEP)
  ) u_phase_seq (
    .clk     (clk),
    .rst     (rst),
    .advance (step_fire),
    .dir     (dir_q),
    .pattern (pattern)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = ((steps == '0) || limit_start) ? DONE : RUN;
      RUN:  if (boundary && (limit_run || (remaining_q == STEP_W'(1)))) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dir_d         = dir_q;
    period_m1_d   = period_m1_q;
    timer_d       = timer_q;
    remaining_d   = remaining_q;
    steps_taken_d = steps_taken_q;
    aborted_d     = aborted_q;
    energised_d   = energised_q;
    if (start_acc) begin
      dir_d         = dir;
      period_m1_d   = period_in_m1;
      timer_d       = period_in_m1;
      remaining_d   = steps;
      steps_taken_d = '0;
      aborted_d     = (steps != '0) && limit_start;
      energised_d   = 1'b1;
    end else if (state_q == RUN) begin
      if (timer_q != '0) begin
        timer_d = timer_q - DIV_W'(1);
      end else if (limit_run) begin
        aborted_d = 1'b1;
      end else begin
        steps_taken_d = steps_taken_q + STEP_W'(1);
        remaining_d   = remaining_q - STEP_W'(1);
        timer_d       = period_m1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q         <= DIR_FWD;
      period_m1_q   <= '0;
      timer_q       <= '0;
      remaining_q   <= '0;
      steps_taken_q <= '0;
      aborted_q     <= 1'b0;
      energised_q   <= 1'b0;
    end else begin
      dir_q         <= dir_d;
      period_m1_q   <= period_m1_d;
      timer_q       <= timer_d;
      remaining_q   <= remaining_d;
      steps_taken_q <= steps_taken_d;
      aborted_q     <= aborted_d;
      energised_q   <= energised_d;
    end
  end

  // Holding only applies once a move has set a phase; straight out of reset the coils stay off.
  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    aborted     = aborted_q;
    steps_taken = steps_taken_q;
    coils       = 4'b0000;
    if ((state_q != IDLE) || (HOLD && energised_q)) coils = pattern;
  end

endmodule
